// File: rtl/bcd_counter_4digit.sv
// Four-digit BCD up/down event counter (0000-9999) with an internal rate prescaler.
// Digits are registered and always hold valid BCD codes 0-9.
module bcd_counter_4digit #(
    parameter int unsigned TICK_DIV = 10_000_000,
    parameter int unsigned TICK_W   = 24
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        en,
    input  logic        up_dn,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thousands,
    output logic        tick,
    output logic        wrap
);

    localparam logic [TICK_W-1:0] PreMax = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] r_pre_cnt;
    logic [3:0][3:0]   r_dig;
    logic              r_tick;
    logic              r_wrap;

    logic              w_step;
    logic [3:0][3:0]   w_dig_up;
    logic [3:0][3:0]   w_dig_dn;
    logic [3:0][3:0]   w_dig_step;
    logic [3:0][3:0]   w_dig_load;
    logic              w_cy_up;
    logic              w_cy_dn;
    logic              w_wrap_step;

    function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic ci);
        if (!ci) begin
            return {1'b0, d};
        end else if (d >= 4'd9) begin
            return {1'b1, 4'd0};
        end else begin
            return {1'b0, d + 4'd1};
        end
    endfunction

    function automatic logic [4:0] bcd_dec(input logic [3:0] d, input logic bi);
        if (!bi) begin
            return {1'b0, d};
        end else if (d == 4'd0) begin
            return {1'b1, 4'd9};
        end else begin
            return {1'b0, d - 4'd1};
        end
    endfunction

    assign w_step = en && (r_pre_cnt == PreMax);

    // Ripple carry/borrow through all four digits in one cycle.
    always_comb begin
        w_dig_up = '0;
        w_dig_dn = '0;
        w_cy_up  = 1'b1;
        w_cy_dn  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {w_cy_up, w_dig_up[i]} = bcd_inc(r_dig[i], w_cy_up);
            {w_cy_dn, w_dig_dn[i]} = bcd_dec(r_dig[i], w_cy_dn);
        end
    end

    always_comb begin
        w_dig_step  = up_dn ? w_dig_up : w_dig_dn;
        w_wrap_step = up_dn ? w_cy_up : w_cy_dn;
    end

    // Out-of-range preset nibbles saturate so the display never sees 10-15.
    always_comb begin
        w_dig_load = '0;
        for (int i = 0; i < 4; i++) begin
            w_dig_load[i] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_pre_cnt <= '0;
            r_dig     <= '0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
        end else if (clr) begin
            r_pre_cnt <= '0;
            r_dig     <= '0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
        end else if (load) begin
            r_pre_cnt <= '0;
            r_dig     <= w_dig_load;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
        end else if (w_step) begin
            r_pre_cnt <= '0;
            r_dig     <= w_dig_step;
            r_tick    <= 1'b1;
            r_wrap    <= w_wrap_step;
        end else begin
            if (en) begin
                r_pre_cnt <= r_pre_cnt + TICK_W'(1);
            end
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign ones      = r_dig[0];
    assign tens      = r_dig[1];
    assign hundreds  = r_dig[2];
    assign thousands = r_dig[3];
    assign tick      = r_tick;
    assign wrap      = r_wrap;

endmodule
